// File: rtl/dot3_mac.sv
// Three-term signed dot-product sequencer around an external 11x8 pipelined multiplier.
// Build option: define DOT3_ROUND_EN to round half toward +inf before scaling (default: floor).
module dot3_mac #(
    parameter int unsigned MULT_LAT = 8,
    parameter int unsigned SHIFT    = 7,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_a,
    input  logic [7:0]  in_b,
    output logic [10:0] mult_a,
    output logic [7:0]  mult_b,
    input  logic [18:0] mult_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = $clog2(DEPTH + 1);
    localparam int unsigned SW = 21;
    localparam int unsigned DW = 11;

    logic [1:0]          r_idx;
    logic [RW-1:0]       r_resv;
    logic [MULT_LAT-1:0] r_tag_vld;
    logic [1:0]          r_tag_idx [MULT_LAT];
    logic signed [SW-1:0] r_acc;
    logic                r_res_vld;
    logic [DW-1:0]       r_res;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_cnt;

    logic                 w_fire;
    logic                 w_pop;
    logic                 w_tag_vld;
    logic [1:0]           w_tag_idx;
    logic signed [SW-1:0] w_p_ext;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_rnd;
    logic signed [SW-1:0] w_shf;
    logic [DW-1:0]        w_sat;

    // Mid-group beats are always accepted; a new group needs a free result slot.
    assign in_ready  = (r_idx != 2'd0) || (r_resv < RW'(DEPTH));
    assign w_fire    = in_valid && in_ready;
    assign mult_a    = w_fire ? in_a : '0;
    assign mult_b    = w_fire ? in_b : '0;

    assign out_valid = (r_cnt != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;

    assign w_tag_vld = r_tag_vld[MULT_LAT-1];
    assign w_tag_idx = r_tag_idx[MULT_LAT-1];

    // Product sign-extension, group sum, scaling and saturation.
    assign w_p_ext = {{(SW-19){mult_p[18]}}, mult_p};
    assign w_sum   = r_acc + w_p_ext;
`ifdef DOT3_ROUND_EN
    assign w_rnd   = w_sum + SW'(1 << (SHIFT - 1));
`else
    assign w_rnd   = w_sum;
`endif
    assign w_shf   = w_rnd >>> SHIFT;

    always_comb begin
        w_sat = w_shf[DW-1:0];
        if (w_shf > 21'sd1023) begin
            w_sat = 11'h3FF;
        end else if (w_shf < -21'sd1024) begin
            w_sat = 11'h400;
        end
    end

    // Element counter within the current group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_fire) begin
            r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end
    end

    // Reserved result slots: claimed at a group's first beat, released on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resv <= '0;
        end else begin
            case ({w_fire && (r_idx == 2'd0), w_pop})
                2'b10:   r_resv <= r_resv + RW'(1);
                2'b01:   r_resv <= r_resv - RW'(1);
                default: r_resv <= r_resv;
            endcase
        end
    end

    // Tag pipeline matched to multiplier latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i < int'(MULT_LAT); i++) begin
                r_tag_idx[i] <= 2'd0;
            end
        end else begin
            r_tag_vld    <= {r_tag_vld[MULT_LAT-2:0], w_fire};
            r_tag_idx[0] <= r_idx;
            for (int i = 1; i < int'(MULT_LAT); i++) begin
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    // Accumulate products; the completed, saturated sum is staged one cycle before the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
        end else begin
            r_res_vld <= w_tag_vld && (w_tag_idx == 2'd2);
            if (w_tag_vld) begin
                case (w_tag_idx)
                    2'd0:    r_acc <= w_p_ext;
                    2'd1:    r_acc <= w_sum;
                    default: r_acc <= r_acc;
                endcase
                if (w_tag_idx == 2'd2) begin
                    r_res <= w_sat;
                end
            end
        end
    end

    // Result FIFO; reservation guarantees a write never meets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_res_vld) begin
                r_mem[r_wr_ptr] <= r_res;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({r_res_vld, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dot3_mac.sv
// Scoreboard bench for dot3_mac with a behavioural model of the pipelined multiplier.
module tb_dot3_mac;

    localparam int MULT_LAT = 8;
    localparam int SHIFT    = 7;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_a;
    logic [7:0]  in_b;
    logic [10:0] mult_a;
    logic [7:0]  mult_b;
    logic [18:0] mult_p;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;

    int n_chk = 0;
    int n_err = 0;
    int q[$];
    int m_idx = 0;
    int m_resv = 0;
    int pops = 0;
    int last_pop = 0;
    int ga[3];
    int gb[3];
    bit rnd_or = 1'b0;

    dot3_mac #(.MULT_LAT(MULT_LAT), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Multiplier model: product registered at the sampling edge, MULT_LAT stages deep.
    logic signed [18:0] ma_ext, mb_ext;
    logic signed [18:0] mpipe [MULT_LAT];
    assign ma_ext = 19'($signed(mult_a));
    assign mb_ext = 19'($signed(mult_b));
    assign mult_p = mpipe[MULT_LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= ma_ext * mb_ext;
        for (int i = 1; i < MULT_LAT; i++) mpipe[i] <= mpipe[i-1];
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_dot(input int a0, input int b0, input int a1,
                                   input int b1, input int a2, input int b2);
        int s;
        s = a0 * b0 + a1 * b1 + a2 * b2;
`ifdef DOT3_ROUND_EN
        s = s + (1 << (SHIFT - 1));
`endif
        s = s >>> SHIFT;
        if (s > 1023) s = 1023;
        if (s < -1024) s = -1024;
        return s;
    endfunction

    // Scoreboard: handshakes are read at the falling edge, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_idx  = 0;
            m_resv = 0;
        end else begin
            check_val("in_ready", int'(in_ready), int'((m_idx != 0) || (m_resv < DEPTH)));
            if (in_valid && in_ready) begin
                ga[m_idx] = int'($signed(in_a));
                gb[m_idx] = int'($signed(in_b));
                if (m_idx == 0) m_resv++;
                if (m_idx == 2) begin
                    q.push_back(ref_dot(ga[0], gb[0], ga[1], gb[1], ga[2], gb[2]));
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("spurious_result", int'($signed(out_data)), 99999);
                end else begin
                    last_pop = int'($signed(out_data));
                    check_val("out_data", last_pop, q.pop_front());
                end
                m_resv--;
                pops++;
            end
        end
    end

    // Random back-pressure generator for the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic beat(input int a, input int b);
        int n;
        in_valid = 1'b1;
        in_a     = 11'(a);
        in_b     = 8'(b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) check_val("beat_accept_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int p0;
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_data", int'(out_data), 0);
        check_val("rst_mult_a", int'(mult_a), 0);
        check_val("rst_mult_b", int'(mult_b), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic group and third-beat-to-result latency.
        beat(100, 64);
        beat(-200, 64);
        beat(50, -128);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check_val("latency", lat, 9);
        check_val("basic_result", int'($signed(out_data)), -100);
        drain();

        // Saturation in both directions.
        for (int k = 0; k < 3; k++) beat(1023, 127);
        drain();
        check_val("sat_pos", last_pop, 1023);
        for (int k = 0; k < 3; k++) beat(-1024, 127);
        drain();
        check_val("sat_neg", last_pop, -1024);

        // Rounding boundary: 64 / 128.
        beat(1, 64);
        beat(0, 0);
        beat(0, 0);
        drain();
`ifdef DOT3_ROUND_EN
        check_val("round_half", last_pop, 1);
`else
        check_val("round_half", last_pop, 0);
`endif

        // Back-pressure: four groups fill the FIFO, the fifth group's first beat must wait.
        p0 = pops;
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 3; k++) beat(37 * g - 300 + 91 * k, 40 - 25 * k + g);
        repeat (15) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 11'(-77);
        in_b     = 8'(90);
        @(negedge clk);
        check_val("bp_in_ready_low", int'(in_ready), 0);
        check_val("bp_out_valid", int'(out_valid), 1);
        check_val("bp_no_early_pop", pops - p0, 0);
        fork
            begin
                for (int g = 4; g < 6; g++)
                    for (int k = 0; k < 3; k++) beat(-77 + 13 * k + g, 90 - 50 * k);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("bp_pop_count", pops - p0, 6);

        // Reset with one group in flight and a partial group pending.
        for (int k = 0; k < 3; k++) beat(10, 64);
        beat(5, 5);
        beat(6, 6);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0   = pops;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_val("rst_no_result", int'(seen), 0);
        check_val("rst_no_pop", pops - p0, 0);
        for (int k = 0; k < 3; k++) beat(2, 64);
        drain();
        check_val("post_rst_result", last_pop, 3);

        // Random soak with input gaps and random consumer stalls.
        p0 = pops;
        rnd_or = 1'b1;
        for (int g = 0; g < 10000; g++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                beat(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 255)) - 128);
            end
        end
        rnd_or = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check_val("rand_pop_count", pops - p0, 10000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
